// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
// Holds the FSM state encoding and the last-beat keep computation.
package axis_pkt_gen_pkg;

    localparam int MAX_KEEP = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } pkt_gen_state_t;

    // Keep mask for a beat carrying `len` valid bytes on a bus of `bytes` lanes.
    // A len of `bytes` or more yields all lanes set.
    function automatic logic [MAX_KEEP-1:0] len_to_tkeep(input logic [31:0] len,
                                                         input int unsigned bytes);
        logic [MAX_KEEP-1:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            keep[i] = (i < len) && (i < bytes);
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream traffic source: emits n_pkts packets of pkt_len bytes with a
// programmable idle gap and a deterministic {pkt_idx, beat_idx} payload.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int LEN_BITS  = 32,
    parameter int GAP_BITS  = 16
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [LEN_BITS-1:0]    pkt_len,
    input  logic [31:0]            n_pkts,
    input  logic [GAP_BITS-1:0]    gap_cycles,
    output logic                   busy,
    output logic                   done,
    output logic [63:0]            byte_cnt,
    output logic [63:0]            pkt_cnt,
    output logic [63:0]            stall_cnt,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output pkt_gen_state_t         dbg_state
);

    localparam int BYTES = DATA_BITS / 8;
    localparam int LANES = DATA_BITS / 64;

    pkt_gen_state_t        state_q, state_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [31:0]           npkts_q, npkts_d;
    logic [GAP_BITS-1:0]   gap_q, gap_d;
    logic [GAP_BITS-1:0]   gap_cnt_q, gap_cnt_d;
    logic [LEN_BITS-1:0]   rem_q, rem_d;
    logic [31:0]           pkt_idx_q, pkt_idx_d;
    logic [31:0]           beat_idx_q, beat_idx_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [BYTES-1:0]      tkeep_q, tkeep_d;
    logic [DATA_BITS-1:0]  tdata_q, tdata_d;
    logic [63:0]           byte_cnt_q, byte_cnt_d;
    logic [63:0]           pkt_cnt_q, pkt_cnt_d;
    logic [63:0]           stall_cnt_q, stall_cnt_d;

    logic                  hs;
    logic                  load_en;
    logic [31:0]           ld_pkt;
    logic [31:0]           ld_beat;
    logic [LEN_BITS-1:0]   ld_rem;
    logic                  ld_last;
    logic [MAX_KEEP-1:0]   ld_keep_full;

    // Handshake: a beat transfers on a cycle where tvalid and tready are both
    // high; once tvalid rises, tdata/tkeep/tlast hold until that transfer.
    assign hs = tvalid_q && m_axis_tready;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        npkts_d      = npkts_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        rem_d        = rem_q;
        pkt_idx_d    = pkt_idx_q;
        beat_idx_d   = beat_idx_q;
        stop_pend_d  = stop_pend_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tkeep_d      = tkeep_q;
        tdata_d      = tdata_q;
        byte_cnt_d   = byte_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        load_en      = 1'b0;
        ld_pkt       = pkt_idx_q;
        ld_beat      = 32'd0;
        ld_rem       = rem_q;
        ld_last      = 1'b0;
        ld_keep_full = '0;

        if (hs) begin
            byte_cnt_d = byte_cnt_q + 64'($countones(tkeep_q));
            if (tlast_q) begin
                pkt_cnt_d = pkt_cnt_q + 64'd1;
            end
        end
        if (tvalid_q && !m_axis_tready) begin
            stall_cnt_d = stall_cnt_q + 64'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    byte_cnt_d  = '0;
                    pkt_cnt_d   = '0;
                    stall_cnt_d = '0;
                    if (pkt_len != '0 && n_pkts != '0) begin
                        len_d      = pkt_len;
                        npkts_d    = n_pkts;
                        gap_d      = gap_cycles;
                        pkt_idx_d  = '0;
                        beat_idx_d = '0;
                        rem_d      = pkt_len;
                        load_en    = 1'b1;
                        ld_pkt     = 32'd0;
                        ld_rem     = pkt_len;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hs) begin
                    if (tlast_q) begin
                        if ((pkt_idx_q + 32'd1 == npkts_q) || stop_pend_q || stop) begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            state_d  = ST_FIN;
                        end else begin
                            pkt_idx_d  = pkt_idx_q + 32'd1;
                            beat_idx_d = '0;
                            rem_d      = len_q;
                            if (gap_q == '0) begin
                                load_en = 1'b1;
                                ld_pkt  = pkt_idx_q + 32'd1;
                                ld_rem  = len_q;
                            end else begin
                                tvalid_d  = 1'b0;
                                tlast_d   = 1'b0;
                                gap_cnt_d = gap_q;
                                state_d   = ST_GAP;
                            end
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 32'd1;
                        rem_d      = rem_q - LEN_BITS'(BYTES);
                        load_en    = 1'b1;
                        ld_beat    = beat_idx_q + 32'd1;
                        ld_rem     = rem_q - LEN_BITS'(BYTES);
                    end
                end
            end
            ST_GAP: begin
                if (stop || stop_pend_q) begin
                    state_d = ST_FIN;
                end else if (gap_cnt_q == GAP_BITS'(1)) begin
                    load_en = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_BITS'(1);
                end
            end
            ST_FIN: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Present the beat selected above; rem counts bytes left including it.
        if (load_en) begin
            ld_last      = (ld_rem <= LEN_BITS'(BYTES));
            ld_keep_full = len_to_tkeep(32'(ld_rem), BYTES);
            tvalid_d     = 1'b1;
            tlast_d      = ld_last;
            tkeep_d      = ld_last ? ld_keep_full[BYTES-1:0] : '1;
            tdata_d      = {LANES{ld_pkt, ld_beat}};
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            npkts_q     <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            rem_q       <= '0;
            pkt_idx_q   <= '0;
            beat_idx_q  <= '0;
            stop_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            tdata_q     <= '0;
            byte_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            npkts_q     <= npkts_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            rem_q       <= rem_d;
            pkt_idx_q   <= pkt_idx_d;
            beat_idx_q  <= beat_idx_d;
            stop_pend_q <= stop_pend_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tkeep_q     <= tkeep_d;
            tdata_q     <= tdata_d;
            byte_cnt_q  <= byte_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy          = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done          = (state_q == ST_FIN);
    assign byte_cnt      = byte_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign stall_cnt     = stall_cnt_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: directed runs, beat scoreboard, counter/timing checks.
module tb_axis_pkt_gen;
    import axis_pkt_gen_pkg::*;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic           aclk = 1'b0;
    logic           reset;
    logic           start;
    logic           stop;
    logic [31:0]    pkt_len;
    logic [31:0]    n_pkts;
    logic [15:0]    gap_cycles;
    logic           busy;
    logic           done;
    logic [63:0]    byte_cnt;
    logic [63:0]    pkt_cnt;
    logic [63:0]    stall_cnt;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    pkt_gen_state_t dbg_state;

    axis_pkt_gen #(.DATA_BITS(DW), .LEN_BITS(32), .GAP_BITS(16)) dut (
        .aclk         (aclk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .pkt_len      (pkt_len),
        .n_pkts       (n_pkts),
        .gap_cycles   (gap_cycles),
        .busy         (busy),
        .done         (done),
        .byte_cnt     (byte_cnt),
        .pkt_cnt      (pkt_cnt),
        .stall_cnt    (stall_cnt),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    int cyc = 0;
    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [128:0] exp_q[$];     // {lane64, keep64, last}
    int hs_cyc[$];
    int hs_total = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_base = 0;
    int st_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [KW-1:0] prev_keep;
    logic          prev_last;

    initial forever begin
        logic [128:0] e;
        logic [DW-1:0] exp_data;
        logic [63:0]   lane;
        @(negedge aclk);
        if (prev_stall && m_axis_tvalid === 1'b1) begin
            chk("stall_stable",
                {63'd0, (m_axis_tdata === prev_data) && (m_axis_tkeep === prev_keep) &&
                        (m_axis_tlast === prev_last)}, 64'd1);
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            hs_total++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got lane 0x%0h with no beat expected",
                         m_axis_tdata[63:0]);
            end else begin
                e = exp_q.pop_front();
                lane = e[128:65];
                exp_data = {(DW/64){lane}};
                total++;
                if (m_axis_tdata !== exp_data) begin
                    bad++;
                    $display("FAIL beat_data: got lane0 0x%0h expected every lane 0x%0h",
                             m_axis_tdata[63:0], lane);
                end
                chk("beat_keep", m_axis_tkeep, e[64:1]);
                chk("beat_last", {63'd0, m_axis_tlast}, {63'd0, e[0]});
            end
        end
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
        prev_data  = m_axis_tdata;
        prev_keep  = m_axis_tkeep;
        prev_last  = m_axis_tlast;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_beat(input int p, input int b, input logic [63:0] keep, input logic last);
        exp_q.push_back({p[31:0], b[31:0], keep, last});
    endtask

    task automatic push_pkts(input int len, input int n);
        int nb;
        logic [63:0] keep;
        nb = (len + 63) / 64;
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < nb; b++) begin
                keep = 64'hFFFF_FFFF_FFFF_FFFF;
                if (b == nb - 1 && (len % 64) != 0) keep = (64'd1 << (len % 64)) - 64'd1;
                push_beat(p, b, keep, b == nb - 1);
            end
        end
    endtask

    task automatic launch(input int len, input int n, input int gap);
        pkt_len    = len;
        n_pkts     = n;
        gap_cycles = 16'(gap);
        start      = 1'b1;
        st_cyc     = cyc;
        done_base  = done_cnt;
        hs_cyc.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == done_base && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", {63'd0, done_cnt > done_base}, 64'd1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
        pkt_len = '0; n_pkts = '0; gap_cycles = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_byte_cnt", byte_cnt, 64'd0);
        chk("rst_pkt_cnt", pkt_cnt, 64'd0);
        chk("rst_stall_cnt", stall_cnt, 64'd0);
        chk("rst_tkeep", m_axis_tkeep, 64'd0);
        chk("rst_tdata", m_axis_tdata[63:0], 64'd0);

        // single full beat
        push_pkts(64, 1);
        launch(64, 1, 0);
        wait_done(50);
        chk("t1_first_beat_cyc", 64'(hs_cyc[0]), 64'(st_cyc + 1));
        chk("t1_done_cyc", 64'(done_cyc), 64'(st_cyc + 2));
        chk("t1_byte_cnt", byte_cnt, 64'd64);
        chk("t1_pkt_cnt", pkt_cnt, 64'd1);
        chk("t1_stall_cnt", stall_cnt, 64'd0);
        chk("t1_done_pulses", 64'(done_cnt - done_base), 64'd1);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // partial last beat, back-to-back packets
        push_pkts(130, 3);
        launch(130, 3, 0);
        wait_done(100);
        chk("t2_beats", 64'(hs_cyc.size()), 64'd9);
        chk("t2_contiguous", 64'(hs_cyc[8] - hs_cyc[0]), 64'd8);
        chk("t2_byte_cnt", byte_cnt, 64'd390);
        chk("t2_pkt_cnt", pkt_cnt, 64'd3);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // backpressure for 5 cycles on beat 2
        push_pkts(256, 2);
        launch(256, 2, 0);
        tick();
        m_axis_tready = 1'b0;
        repeat (5) tick();
        m_axis_tready = 1'b1;
        wait_done(100);
        chk("t3_stall_cnt", stall_cnt, 64'd5);
        chk("t3_byte_cnt", byte_cnt, 64'd512);
        chk("t3_pkt_cnt", pkt_cnt, 64'd2);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // inter-packet gap of 4 cycles
        push_pkts(64, 3);
        launch(64, 3, 4);
        wait_done(100);
        chk("t4_beats", 64'(hs_cyc.size()), 64'd3);
        chk("t4_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd5);
        chk("t4_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd5);
        chk("t4_no_trailing_gap", 64'(done_cyc), 64'(hs_cyc[2] + 1));
        chk("t4_pkt_cnt", pkt_cnt, 64'd3);
        chk("t4_byte_cnt", byte_cnt, 64'd192);

        // stop during first beat of packet 4, plus ignored restart
        push_pkts(128, 4);
        launch(128, 10, 0);
        tick();
        tick();
        pkt_len = 64; n_pkts = 1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(200);
        chk("t5_pkt_cnt", pkt_cnt, 64'd4);
        chk("t5_byte_cnt", byte_cnt, 64'd512);
        chk("t5_beats", 64'(hs_cyc.size()), 64'd8);
        chk("t5_done_pulses", 64'(done_cnt - done_base), 64'd1);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset mid-packet, then empty run
        push_beat(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        push_beat(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        push_beat(0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        launch(256, 1, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_done", {63'd0, done}, 64'd0);
        chk("t6_byte_cnt", byte_cnt, 64'd0);
        chk("t6_pkt_cnt", pkt_cnt, 64'd0);
        tick();
        chk("t6_no_done", 64'(done_cnt - done_base), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        launch(64, 0, 0);
        wait_done(20);
        chk("t6_zero_run_beats", 64'(hs_cyc.size()), 64'd0);
        chk("t6_zero_run_done", 64'(done_cnt - done_base), 64'd1);
        chk("t6_zero_run_busy", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
